// File: rtl/rv32_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fetch
// Brief    : RV32 instruction fetch stage with static branch prediction,
//            one-entry hold buffer, flush/drain handling and fetch exceptions.
// Revision : 1.0
// ============================================================================
module rv32_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [31:0] branch_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    input  logic        instr_fault_in,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  exception_cause_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    localparam logic [1:0]  FETCH = 2'd0;
    localparam logic [1:0]  DRAIN = 2'd1;
    localparam logic [1:0]  HALT  = 2'd2;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [3:0]  CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0]  CAUSE_FAULT      = 4'd1;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic        drain_halt;
    logic        started;

    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic        buf_pred;
    logic        buf_fault;

    logic [6:0]  opcode;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic        is_jal;
    logic        is_bwd_branch;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic        fetch_resp;
    logic [31:0] resp_instr;
    logic        flush_misaligned;

    // Static predictor: JAL and backward conditional branches are taken,
    // unless the target is misaligned (execute raises that).
    assign opcode        = instr_read_value_in[6:0];
    assign imm_j         = {{12{instr_read_value_in[31]}}, instr_read_value_in[19:12],
                            instr_read_value_in[20], instr_read_value_in[30:21], 1'b0};
    assign imm_b         = {{20{instr_read_value_in[31]}}, instr_read_value_in[7],
                            instr_read_value_in[30:25], instr_read_value_in[11:8], 1'b0};
    assign is_jal        = (opcode == OPC_JAL);
    assign is_bwd_branch = (opcode == OPC_BRANCH) && instr_read_value_in[31];
    assign target        = is_jal ? (pc + imm_j) : (pc + imm_b);
    assign pred_taken    = (is_jal || is_bwd_branch) && (target[1:0] == 2'b00)
                           && !instr_fault_in;
    assign next_pc       = pred_taken ? target : (pc + 32'd4);

    assign instr_read_out    = started && (((state == FETCH) && !buf_valid)
                                           || (state == DRAIN));
    assign instr_address_out = (state == DRAIN) ? drain_addr : pc;

    assign fetch_resp       = (state == FETCH) && instr_read_out && instr_ready_in;
    assign resp_instr       = instr_fault_in ? NOP : instr_read_value_in;
    assign flush_misaligned = (branch_pc_in[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                      <= FETCH;
            pc                         <= RESET_PC;
            drain_addr                 <= RESET_PC;
            drain_halt                 <= 1'b0;
            started                    <= 1'b0;
            buf_valid                  <= 1'b0;
            buf_pc                     <= 32'd0;
            buf_instr                  <= NOP;
            buf_pred                   <= 1'b0;
            buf_fault                  <= 1'b0;
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            exception_cause_out        <= 4'd0;
            branch_predicted_taken_out <= 1'b0;
            pc_out                     <= 32'd0;
            instr_out                  <= NOP;
        end else begin
            started <= 1'b1;
            if (flush_in) begin
                buf_valid                  <= 1'b0;
                pc                         <= branch_pc_in;
                branch_predicted_taken_out <= 1'b0;
                if (flush_misaligned) begin
                    valid_out           <= 1'b1;
                    exception_out       <= 1'b1;
                    exception_cause_out <= CAUSE_MISALIGNED;
                    pc_out              <= branch_pc_in;
                    instr_out           <= NOP;
                end else begin
                    valid_out     <= 1'b0;
                    exception_out <= 1'b0;
                end
                // An outstanding bus request must still complete before redirecting.
                if (instr_read_out && !instr_ready_in) begin
                    state      <= DRAIN;
                    drain_addr <= instr_address_out;
                    drain_halt <= flush_misaligned;
                end else begin
                    state <= flush_misaligned ? HALT : FETCH;
                end
            end else begin
                if (stall_in) begin
                    if (fetch_resp) begin
                        buf_valid <= 1'b1;
                        buf_pc    <= pc;
                        buf_instr <= resp_instr;
                        buf_pred  <= pred_taken;
                        buf_fault <= instr_fault_in;
                    end
                end else if (buf_valid) begin
                    buf_valid                  <= 1'b0;
                    valid_out                  <= 1'b1;
                    exception_out              <= buf_fault;
                    exception_cause_out        <= buf_fault ? CAUSE_FAULT : 4'd0;
                    branch_predicted_taken_out <= buf_pred;
                    pc_out                     <= buf_pc;
                    instr_out                  <= buf_instr;
                end else if (fetch_resp) begin
                    valid_out                  <= 1'b1;
                    exception_out              <= instr_fault_in;
                    exception_cause_out        <= instr_fault_in ? CAUSE_FAULT : 4'd0;
                    branch_predicted_taken_out <= pred_taken;
                    pc_out                     <= pc;
                    instr_out                  <= resp_instr;
                end else begin
                    valid_out     <= 1'b0;
                    exception_out <= 1'b0;
                end

                case (state)
                    FETCH: begin
                        if (fetch_resp) begin
                            if (instr_fault_in) begin
                                state <= HALT;
                            end else begin
                                pc <= next_pc;
                            end
                        end
                    end
                    DRAIN: begin
                        if (instr_ready_in) begin
                            state <= drain_halt ? HALT : FETCH;
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_fetch
// Brief    : Directed self-checking bench for rv32_fetch.
// Revision : 1.0
// ============================================================================
module tb_rv32_fetch;

    logic        clk;
    logic        reset_n;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] branch_pc_in;
    logic        instr_read_out;
    logic [31:0] instr_address_out;
    logic        instr_ready_in;
    logic [31:0] instr_read_value_in;
    logic        instr_fault_in;
    logic        valid_out;
    logic        exception_out;
    logic [3:0]  exception_cause_out;
    logic        branch_predicted_taken_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int errors;
    int checks;

    // Bus responder: NOP everywhere except a few table entries, optional wait states.
    logic [31:0] sp_addr [0:1];
    logic [31:0] sp_data [0:1];
    logic [31:0] fault_addr;
    logic        fault_en;
    int          wait_states;
    int          wait_left;

    rv32_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .stall_in                   (stall_in),
        .flush_in                   (flush_in),
        .branch_pc_in               (branch_pc_in),
        .instr_read_out             (instr_read_out),
        .instr_address_out          (instr_address_out),
        .instr_ready_in             (instr_ready_in),
        .instr_read_value_in        (instr_read_value_in),
        .instr_fault_in             (instr_fault_in),
        .valid_out                  (valid_out),
        .exception_out              (exception_out),
        .exception_cause_out        (exception_cause_out),
        .branch_predicted_taken_out (branch_predicted_taken_out),
        .pc_out                     (pc_out),
        .instr_out                  (instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        instr_read_value_in = 32'h0000_0013;
        for (int i = 0; i < 2; i++) begin
            if (sp_addr[i] == instr_address_out) instr_read_value_in = sp_data[i];
        end
    end

    assign instr_ready_in = instr_read_out && (wait_left == 0);
    assign instr_fault_in = instr_ready_in && fault_en && (instr_address_out == fault_addr);

    always @(posedge clk) begin
        if (!instr_read_out || instr_ready_in) wait_left <= wait_states;
        else if (wait_left != 0)               wait_left <= wait_left - 1;
    end

    task automatic do_flush(input logic [31:0] target);
        flush_in     = 1'b1;
        branch_pc_in = target;
        @(negedge clk);
        flush_in     = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (instr_read_out !== 1'b0) begin errors++; $display("FAIL rst_read: got %b want 0", instr_read_out); end
        checks++; if (instr_address_out !== 32'h100) begin errors++; $display("FAIL rst_addr: got %h want 00000100", instr_address_out); end
        checks++; if (valid_out !== 1'b0 || exception_out !== 1'b0 || branch_predicted_taken_out !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got v=%b e=%b p=%b want 000", valid_out, exception_out, branch_predicted_taken_out); end
        checks++; if (pc_out !== 32'h0 || instr_out !== 32'h13 || exception_cause_out !== 4'd0) begin
            errors++; $display("FAIL rst_slot: got pc=%h instr=%h cause=%0d want 0/13/0", pc_out, instr_out, exception_cause_out); end
        reset_n = 1'b1;
    endtask

    task automatic test_sequential;
        @(negedge clk);
        checks++; if (instr_read_out !== 1'b1 || instr_address_out !== 32'h100) begin
            errors++; $display("FAIL seq_first: got rd=%b addr=%h want 1/00000100", instr_read_out, instr_address_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL seq_bubble: got valid=%b want 0", valid_out); end
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h104 || pc_out !== 32'h100 || valid_out !== 1'b1) begin
            errors++; $display("FAIL seq_1: got addr=%h pc=%h v=%b want 104/100/1", instr_address_out, pc_out, valid_out); end
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h108 || pc_out !== 32'h104 || valid_out !== 1'b1) begin
            errors++; $display("FAIL seq_2: got addr=%h pc=%h v=%b want 108/104/1", instr_address_out, pc_out, valid_out); end
    endtask

    task automatic test_predict;
        sp_data[0] = 32'h0200_006F;  // JAL x0,+0x20 at 0x100
        do_flush(32'h100);
        checks++; if (instr_address_out !== 32'h100 || valid_out !== 1'b0) begin
            errors++; $display("FAIL jal_redirect: got addr=%h v=%b want 100/0", instr_address_out, valid_out); end
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h120 || branch_predicted_taken_out !== 1'b1 || pc_out !== 32'h100
                      || instr_out !== 32'h0200_006F) begin
            errors++; $display("FAIL jal_taken: got addr=%h pred=%b pc=%h instr=%h want 120/1/100/0200006f",
                               instr_address_out, branch_predicted_taken_out, pc_out, instr_out); end

        sp_data[0] = 32'h0220_006F;  // JAL x0,+0x22: misaligned target, not taken
        do_flush(32'h100);
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h104 || branch_predicted_taken_out !== 1'b0) begin
            errors++; $display("FAIL jal_misaligned: got addr=%h pred=%b want 104/0", instr_address_out, branch_predicted_taken_out); end

        sp_data[1] = 32'hFE00_0CE3;  // BEQ x0,x0,-8 at 0x200
        do_flush(32'h200);
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h1F8 || branch_predicted_taken_out !== 1'b1 || pc_out !== 32'h200) begin
            errors++; $display("FAIL beq_back: got addr=%h pred=%b pc=%h want 1f8/1/200", instr_address_out, branch_predicted_taken_out, pc_out); end

        sp_data[1] = 32'h0000_0463;  // BEQ x0,x0,+8
        do_flush(32'h200);
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h204 || branch_predicted_taken_out !== 1'b0 || valid_out !== 1'b1) begin
            errors++; $display("FAIL beq_fwd: got addr=%h pred=%b v=%b want 204/0/1", instr_address_out, branch_predicted_taken_out, valid_out); end
        sp_data[0] = 32'h13;
        sp_data[1] = 32'h13;
    endtask

    task automatic test_wrap;
        do_flush(32'hFFFF_FFFC);
        @(negedge clk);
        checks++; if (instr_address_out !== 32'h0 || pc_out !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap: got addr=%h pc=%h want 00000000/fffffffc", instr_address_out, pc_out); end
    endtask

    task automatic test_stall;
        do_flush(32'h100);
        @(negedge clk);            // slot 0x100 loaded, request 0x104 live
        stall_in = 1'b1;           // response for 0x104 lands in the hold buffer
        @(negedge clk);
        checks++; if (instr_read_out !== 1'b0 || pc_out !== 32'h100 || valid_out !== 1'b1) begin
            errors++; $display("FAIL stall_hold1: got rd=%b pc=%h v=%b want 0/100/1", instr_read_out, pc_out, valid_out); end
        @(negedge clk);
        stall_in = 1'b0;
        checks++; if (instr_read_out !== 1'b0 || pc_out !== 32'h100) begin
            errors++; $display("FAIL stall_hold2: got rd=%b pc=%h want 0/100", instr_read_out, pc_out); end
        @(negedge clk);
        checks++; if (pc_out !== 32'h104 || valid_out !== 1'b1 || instr_read_out !== 1'b1 || instr_address_out !== 32'h108) begin
            errors++; $display("FAIL stall_release: got pc=%h v=%b rd=%b addr=%h want 104/1/1/108",
                               pc_out, valid_out, instr_read_out, instr_address_out); end
    endtask

    task automatic test_drain;
        int seen_300;
        seen_300 = 0;
        wait_states = 2;
        do_flush(32'h300);
        @(negedge clk);            // request 0x300 in its second wait cycle
        checks++; if (instr_address_out !== 32'h300 || instr_ready_in !== 1'b0) begin
            errors++; $display("FAIL drain_setup: got addr=%h rdy=%b want 300/0", instr_address_out, instr_ready_in); end
        do_flush(32'h400);
        checks++; if (instr_read_out !== 1'b1 || instr_address_out !== 32'h300) begin
            errors++; $display("FAIL drain_hold: got rd=%b addr=%h want 1/300", instr_read_out, instr_address_out); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1 && pc_out === 32'h300) seen_300 = 1;
            if (i == 0) begin
                checks++; if (instr_read_out !== 1'b1 || instr_address_out !== 32'h400) begin
                    errors++; $display("FAIL drain_next: got rd=%b addr=%h want 1/400", instr_read_out, instr_address_out); end
            end
        end
        checks++; if (seen_300 != 0 || valid_out !== 1'b1 || pc_out !== 32'h400) begin
            errors++; $display("FAIL drain_slot: got seen300=%0d v=%b pc=%h want 0/1/400", seen_300, valid_out, pc_out); end
        wait_states = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_fault;
        fault_addr = 32'h500;
        fault_en   = 1'b1;
        do_flush(32'h500);
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || exception_out !== 1'b1 || exception_cause_out !== 4'd1
                      || instr_out !== 32'h13 || pc_out !== 32'h500) begin
            errors++; $display("FAIL fault_slot: got v=%b e=%b c=%0d instr=%h pc=%h want 1/1/1/13/500",
                               valid_out, exception_out, exception_cause_out, instr_out, pc_out); end
        checks++; if (instr_read_out !== 1'b0) begin errors++; $display("FAIL fault_halt0: got rd=%b want 0", instr_read_out); end
        repeat (2) @(negedge clk);
        checks++; if (instr_read_out !== 1'b0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL fault_halt2: got rd=%b v=%b want 0/0", instr_read_out, valid_out); end
        fault_en = 1'b0;
        do_flush(32'h600);
        checks++; if (instr_read_out !== 1'b1 || instr_address_out !== 32'h600 || exception_out !== 1'b0) begin
            errors++; $display("FAIL fault_resume: got rd=%b addr=%h e=%b want 1/600/0", instr_read_out, instr_address_out, exception_out); end
    endtask

    task automatic test_misaligned;
        do_flush(32'h402);
        checks++; if (valid_out !== 1'b1 || exception_out !== 1'b1 || exception_cause_out !== 4'd0
                      || pc_out !== 32'h402 || instr_out !== 32'h13) begin
            errors++; $display("FAIL misal_slot: got v=%b e=%b c=%0d pc=%h instr=%h want 1/1/0/402/13",
                               valid_out, exception_out, exception_cause_out, pc_out, instr_out); end
        checks++; if (instr_read_out !== 1'b0) begin errors++; $display("FAIL misal_noreq: got rd=%b want 0", instr_read_out); end
        @(negedge clk);
        checks++; if (instr_read_out !== 1'b0) begin errors++; $display("FAIL misal_halt: got rd=%b want 0", instr_read_out); end
        do_flush(32'h800);
        checks++; if (instr_read_out !== 1'b1 || instr_address_out !== 32'h800 || valid_out !== 1'b0 || exception_out !== 1'b0) begin
            errors++; $display("FAIL misal_resume: got rd=%b addr=%h v=%b e=%b want 1/800/0/0",
                               instr_read_out, instr_address_out, valid_out, exception_out); end
        @(negedge clk);
    endtask

    task automatic test_flush_in_stall;
        stall_in = 1'b1;
        do_flush(32'h900);
        checks++; if (valid_out !== 1'b0 || instr_address_out !== 32'h900) begin
            errors++; $display("FAIL flush_stall: got v=%b addr=%h want 0/900", valid_out, instr_address_out); end
        stall_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b0;
        stall_in     = 1'b0;
        flush_in     = 1'b0;
        branch_pc_in = 32'h0;
        sp_addr[0]   = 32'h100;
        sp_addr[1]   = 32'h200;
        sp_data[0]   = 32'h13;
        sp_data[1]   = 32'h13;
        fault_addr   = 32'h0;
        fault_en     = 1'b0;
        wait_states  = 0;
        @(negedge clk);
        test_reset;
        test_sequential;
        test_predict;
        test_wrap;
        test_stall;
        test_drain;
        test_fault;
        test_misaligned;
        test_flush_in_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
